// File: rtl/hex_digit_sched.sv
// hex_digit_sched: round-robin arbitrated BCD digit registers with blank mask and blink phase.
// Optional LAMP_TEST_EN adds a lamp_test input that forces every digit to a lit 8.
module hex_digit_sched #(
    parameter int unsigned NDIG      = 6,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_a,
    input  logic [2:0]        idx_a,
    input  logic [3:0]        val_a,
    input  logic              req_b,
    input  logic [2:0]        idx_b,
    input  logic [3:0]        val_b,
    output logic              ack_a,
    output logic              ack_b,
    output logic              err,
    input  logic              clr,
    input  logic [NDIG-1:0]   blink_en,
`ifdef LAMP_TEST_EN
    input  logic              lamp_test,
`endif
    output logic [4*NDIG-1:0] bcd_out,
    output logic [NDIG-1:0]   blank_out
);
    localparam int unsigned CW = $clog2(BLINK_DIV);

    typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

    state_t               state_q, state_d;
    logic                 last_b_q, last_b_d;
    logic                 win_b_q, win_b_d;
    logic [2:0]           idx_q, idx_d;
    logic [3:0]           val_q, val_d;
    logic                 ack_a_q, ack_a_d, ack_b_q, ack_b_d, err_q, err_d;
    logic [NDIG-1:0][3:0] bcd_q, bcd_d;
    logic [NDIG-1:0]      blank_q, blank_d;
    logic [CW-1:0]        cnt_q;
    logic                 phase_q;
    logic                 grant_b;

    always_comb begin
        grant_b  = req_b && (!req_a || !last_b_q);
        state_d  = state_q;
        last_b_d = last_b_q;
        win_b_d  = win_b_q;
        idx_d    = idx_q;
        val_d    = val_q;
        ack_a_d  = 1'b0;
        ack_b_d  = 1'b0;
        err_d    = 1'b0;
        bcd_d    = bcd_q;
        blank_d  = blank_q;
        case (state_q)
            IDLE: if (req_a || req_b) begin
                state_d = WRITE;
                win_b_d = grant_b;
                idx_d   = grant_b ? idx_b : idx_a;
                val_d   = grant_b ? val_b : val_a;
                if (req_a && req_b) last_b_d = grant_b;
            end
            WRITE: begin
                state_d = HOLD;
                ack_a_d = !win_b_q;
                ack_b_d = win_b_q;
                err_d   = 32'(idx_q) >= NDIG;
                // non-decimal values become a dark digit so the decoder never sees 10..15
                for (int unsigned i = 0; i < NDIG; i++)
                    if (32'(idx_q) == i) begin
                        bcd_d[i]   = (val_q < 4'd10) ? val_q : 4'h0;
                        blank_d[i] = val_q >= 4'd10;
                    end
            end
            default: state_d = IDLE;
        endcase
        if (clr) begin
            bcd_d   = '0;
            blank_d = '1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            last_b_q <= 1'b1;
            win_b_q  <= 1'b0;
            idx_q    <= '0;
            val_q    <= '0;
            ack_a_q  <= 1'b0;
            ack_b_q  <= 1'b0;
            err_q    <= 1'b0;
            bcd_q    <= '0;
            blank_q  <= '1;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_b_q <= last_b_d;
            win_b_q  <= win_b_d;
            idx_q    <= idx_d;
            val_q    <= val_d;
            ack_a_q  <= ack_a_d;
            ack_b_q  <= ack_b_d;
            err_q    <= err_d;
            bcd_q    <= bcd_d;
            blank_q  <= blank_d;
            cnt_q    <= (cnt_q == CW'(BLINK_DIV - 1)) ? '0 : cnt_q + 1'b1;
            phase_q  <= phase_q ^ (cnt_q == CW'(BLINK_DIV - 1));
        end
    end

    assign ack_a = ack_a_q;
    assign ack_b = ack_b_q;
    assign err   = err_q;
`ifdef LAMP_TEST_EN
    assign bcd_out   = lamp_test ? {NDIG{4'h8}} : bcd_q;
    assign blank_out = lamp_test ? '0 : blank_q | (blink_en & {NDIG{phase_q}});
`else
    assign bcd_out   = bcd_q;
    assign blank_out = blank_q | (blink_en & {NDIG{phase_q}});
`endif
endmodule

// File: tb/tb_hex_digit_sched.sv
// tb_hex_digit_sched: directed scoreboard bench for hex_digit_sched with a short blink period.
module tb_hex_digit_sched;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_a = 1'b0, req_b = 1'b0, clr = 1'b0;
    logic [2:0]  idx_a = '0, idx_b = '0;
    logic [3:0]  val_a = '0, val_b = '0;
    logic [5:0]  blink_en = '0;
    logic        ack_a, ack_b, err;
    logic [23:0] bcd_out;
    logic [5:0]  blank_out;
`ifdef LAMP_TEST_EN
    logic        lamp_test = 1'b0;
`endif

    typedef struct {
        bit          b;
        bit          e;
        logic [23:0] bcd;
        logic [5:0]  blank;
    } exp_t;

    exp_t            sb[$];
    logic [5:0][3:0] bcd_m = '0;
    logic [5:0]      blank_m = '1;
    int              n_vec = 0;
    int              n_err = 0;

    hex_digit_sched #(.NDIG(6), .BLINK_DIV(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_a(req_a), .idx_a(idx_a), .val_a(val_a),
        .req_b(req_b), .idx_b(idx_b), .val_b(val_b),
        .ack_a(ack_a), .ack_b(ack_b), .err(err),
        .clr(clr), .blink_en(blink_en),
`ifdef LAMP_TEST_EN
        .lamp_test(lamp_test),
`endif
        .bcd_out(bcd_out), .blank_out(blank_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input bit b, input logic [2:0] idx, input logic [3:0] val);
        exp_t e;
        e.b = b;
        e.e = idx >= 3'd6;
        if (!e.e) begin
            bcd_m[idx]   = (val < 4'd10) ? val : 4'h0;
            blank_m[idx] = val >= 4'd10;
        end
        e.bcd   = bcd_m;
        e.blank = blank_m;
        sb.push_back(e);
    endtask

    task automatic check_ack();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("ack_a", ack_a, !e.b);
            chk("ack_b", ack_b, e.b);
            chk("err", err, e.e);
            chk("bcd", bcd_out, e.bcd);
            chk("blank", blank_out, e.blank);
        end
    endtask

    // Raises the selected requests, drops each one the cycle after its ack, and reports ack cycles.
    task automatic run_reqs(input bit ua, input bit ub, output int t_a, output int t_b);
        bit da = 0, db = 0;
        t_a = -1;
        t_b = -1;
        req_a = ua;
        req_b = ub;
        for (int c = 1; c <= 15 && (req_a || req_b); c++) begin
            @(negedge clk);
            if (da || db) chk("ack_one_cycle", ack_a | ack_b, 0);
            if (da) begin req_a = 0; da = 0; end
            if (db) begin req_b = 0; db = 0; end
            if (ack_a || ack_b) begin
                check_ack();
                if (ack_a) begin t_a = c; da = 1; end
                if (ack_b) begin t_b = c; db = 1; end
            end
        end
        chk("req_timeout", {req_a, req_b}, 0);
        req_a = 0;
        req_b = 0;
    endtask

    initial begin
        int ta, tb, n;
        logic prev, ex;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        chk("rst_bcd", bcd_out, 24'h0);
        chk("rst_blank", blank_out, 6'h3F);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_idle", {ack_a, ack_b, err}, 0);
        end

        idx_a = 3'd2; val_a = 4'd7;
        push_exp(0, 3'd2, 4'd7);
        run_reqs(1, 0, ta, tb);
        chk("lat_a", ta, 2);
        chk("digit2", bcd_out[11:8], 4'd7);
        chk("blank_3b", blank_out, 6'h3B);

        idx_a = 3'd0; val_a = 4'd1; idx_b = 3'd1; val_b = 4'd2;
        push_exp(0, 3'd0, 4'd1);
        push_exp(1, 3'd1, 4'd2);
        run_reqs(1, 1, ta, tb);
        chk("pair1_lat_a", ta, 2);
        chk("pair1_gap", tb - ta, 3);
        chk("pair1_bcd", bcd_out[7:0], 8'h21);

        idx_a = 3'd4; val_a = 4'd3; idx_b = 3'd5; val_b = 4'd9;
        push_exp(1, 3'd5, 4'd9);
        push_exp(0, 3'd4, 4'd3);
        run_reqs(1, 1, ta, tb);
        chk("pair2_lat_b", tb, 2);
        chk("pair2_gap", ta - tb, 3);

        idx_b = 3'd6; val_b = 4'd3;
        push_exp(1, 3'd6, 4'd3);
        run_reqs(0, 1, ta, tb);
        chk("err_lat", tb, 2);
        idx_b = 3'd3; val_b = 4'hC;
        push_exp(1, 3'd3, 4'hC);
        run_reqs(0, 1, ta, tb);
        chk("hex_dark", blank_out[3], 1'b1);
        chk("hex_zero", bcd_out[15:12], 4'h0);

        idx_a = 3'd0; val_a = 4'd5;
        push_exp(0, 3'd0, 4'd5);
        run_reqs(1, 0, ta, tb);
        blink_en = 6'h01;
        #1;
        prev = blank_out[0];
        n = 0;
        do begin @(negedge clk); n++; end while (blank_out[0] === prev && n < 10);
        chk("blink_toggle_seen", n < 10, 1);
        prev = blank_out[0];
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            ex = prev ^ (k % 4 == 0);
            chk("blink_phase", blank_out[0], ex);
            chk("blink_bcd", bcd_out[3:0], 4'd5);
            chk("blink_others", blank_out[5:1], blank_m[5:1]);
            prev = ex;
        end
        blink_en = 6'h00;

`ifdef LAMP_TEST_EN
        @(negedge clk);
        lamp_test = 1'b1;
        #1;
        chk("lamp_bcd", bcd_out, 24'h888888);
        chk("lamp_blank", blank_out, 6'h00);
        @(negedge clk);
        lamp_test = 1'b0;
        #1;
        chk("lamp_restore_bcd", bcd_out, bcd_m);
        chk("lamp_restore_blank", blank_out, blank_m);
`endif

        @(negedge clk);
        idx_a = 3'd2; val_a = 4'd3; req_a = 1'b1;
        bcd_m = '0;
        blank_m = '1;
        sb.push_back('{b: 0, e: 0, bcd: 24'h0, blank: 6'h3F});
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_ack_seen", ack_a, 1'b1);
        check_ack();
        @(negedge clk);
        req_a = 1'b0;
        @(negedge clk);

        idx_a = 3'd1; val_a = 4'd4; req_a = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rstw_acks", {ack_a, ack_b, err}, 0);
        chk("rstw_bcd", bcd_out, 24'h0);
        chk("rstw_blank", blank_out, 6'h3F);
        @(negedge clk);
        req_a = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstw_no_ack", {ack_a, ack_b, err}, 0);
        end
        chk("rstw_bcd_hold", bcd_out, 24'h0);
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/hex_digit_sched.md
Name: hex_digit_sched

Overview:
- Owns the six 4-bit BCD digit registers driving the HEX0..HEX5 seg7 decoders, plus a per-digit blank mask.
- Arbitrates digit writes between two requesters: A = game/feedback logic, B = timer/score logic.
- Adds a free-running blink phase.
- Guarantees the decoders only ever receive codes 0..9; non-decimal content is expressed through the blank mask.

Parameters:
- NDIG, 6, number of digits; index width is clog2(NDIG).
- BLINK_DIV, 25000000, clock cycles per blink half-period; minimum legal value 2.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_a  input  1  requester A write request.
- idx_a  input  3  requester A digit index.
- val_a  input  4  requester A digit value.
- req_b  input  1  requester B write request.
- idx_b  input  3  requester B digit index.
- val_b  input  4  requester B digit value.
- ack_a  output  1  one-cycle acknowledge to A.
- ack_b  output  1  one-cycle acknowledge to B.
- err  output  1  one-cycle pulse, coincident with ack, when the acknowledged index is >= NDIG.
- clr  input  1  synchronous clear; blanks every digit.
- blink_en  input  NDIG  per-digit blink enable.
- lamp_test  input  1  lamp test; only present when LAMP_TEST_EN is defined.
- bcd_out  output  4*NDIG  digit i is bits [4i+3:4i]; connects to seg7 bcd inputs.
- blank_out  output  NDIG  1 = digit i dark; the top level forces its leds to 7'h7F.

Behaviour:
- Reset (asynchronous, reset_n low):
  - FSM returns to IDLE.
  - bcd_out = 0 and all blank bits = 1.
  - ack_a, ack_b and err = 0; any in-flight write is discarded with no ack.
  - Blink counter = 0 and phase = 0.
  - last_grant = B, so A wins the first tie.
- FSM states: IDLE, WRITE, HOLD.
  - IDLE: on a clock edge with req_a or req_b high, latch the winner's index and value and go to WRITE. If neither is high, stay in IDLE.
  - Arbitration: if only one request is high, it wins. If both are high, the requester not equal to last_grant wins (round-robin), and last_grant updates to the winner.
  - WRITE, next edge:
    - Commit the latched write and pulse the winner's ack for exactly one cycle.
    - err pulses alongside ack if the latched index is >= NDIG; no register changes in that case.
    - Go to HOLD.
  - HOLD: one dead cycle so the requester can drop req, then go to IDLE. A req still high in HOLD is treated as a new request in IDLE.
- Requester handshake:
  - Raise req with idx and val stable, and hold until ack.
  - Drop req, or present new data, on the cycle after ack.
  - Latency from first req-high edge to ack-high cycle is 2 clocks.
  - Maximum throughput is 1 write per 3 clocks, shared by both requesters.
- Write rule:
  - val 0..9: bcd[idx] = val, blank[idx] = 0.
  - val 10..15: bcd[idx] = 0, blank[idx] = 1 (digit goes dark, no X propagates).
- clr:
  - Sets all blank bits to 1 and all bcd digits to 0 on the next edge.
  - If clr coincides with the WRITE commit edge, clr wins: the write is dropped, but ack is still issued (and err if applicable).
  - clr does not change FSM state.
- Blink:
  - Counter runs 0..BLINK_DIV-1 and wraps; phase toggles on each wrap.
  - blank_out[i] = blank[i] OR (blink_en[i] AND phase).
  - bcd_out is unaffected by blink; a blinking digit keeps its value across phases.
- Outputs are registered except blank_out, which is a single OR/AND level after registers.

Optional Feature:
- Macro name: LAMP_TEST_EN.
- With the macro defined:
  - The lamp_test port exists.
  - While lamp_test = 1: bcd_out = all 4'h8 and blank_out = 0, overriding stored state and blink.
  - Stored registers and the FSM continue operating; the previous display reappears when lamp_test drops.
- Without the macro: no lamp_test port, and outputs always reflect stored state.

Test Plan:
- Reset release, no requests -> bcd_out = 0, blank_out = 6'h3F, acks and err stay 0 for 10 cycles.
- req_a with idx_a = 2, val_a = 7 -> ack_a high exactly 2 clocks after the first sampled edge; bcd_out[11:8] = 7; blank_out = 6'h3B.
- req_a and req_b raised together and held until each acks (idx_a = 0/val_a = 1, idx_b = 1/val_b = 2) -> A acked first, then B, with acks 3 clocks apart; bcd_out[7:0] = 8'h21; the next simultaneous pair grants B first.
- req_b with idx_b = 6 -> ack_b and err pulse together; no digit or blank bit changes. Then req_b with idx_b = 3, val_b = 4'hC -> blank_out[3] = 1 and bcd_out[15:12] = 0.
- BLINK_DIV = 4 with blink_en = 6'h01 after writing digit 0 = 5 -> blank_out[0] toggles every 4 clocks while bcd_out[3:0] stays 5. Separately, clr on the WRITE commit edge -> ack issued, all digits blank.
- With LAMP_TEST_EN defined, lamp_test = 1 -> bcd_out = 24'h888888 and blank_out = 0. After lamp_test = 0, prior contents return. Asserting reset_n low mid-WRITE -> no ack, all outputs at reset values.
